// File: rtl/mips_if_litebpu_pkg.sv
// Shared types and constants for the IF-stage lite branch-prediction unit.
// Address/regfile-index widths, the link register index and the predictor FSM states.
package mips_if_litebpu_pkg;

   localparam int ADDR_W  = 32;
   localparam int RFIDX_W = 5;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [RFIDX_W-1:0] rfidx_t;

   localparam rfidx_t ZERO_IDX = 5'd0;
   localparam rfidx_t RA_IDX   = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_READ = 2'd2
   } bpu_state_e;

   // Backward-taken/forward-not-taken: a target below the fall-through address loops back.
   function automatic logic is_backward(input addr_t target, input addr_t pc_incr);
      return target < pc_incr;
   endfunction

endpackage

// File: rtl/mips_if_litebpu_if.sv
// IF-stage side of the branch-prediction unit: decode inputs, regfile read port, prediction outputs.
// The master is the fetch pipeline; the slave is the predictor.
interface mips_if_litebpu_if;
   import mips_if_litebpu_pkg::*;

   logic   inst_vld;
   logic   flush;
   addr_t  pc_incr;
   logic   dec_bjp;
   logic   dec_j;
   logic   dec_jal;
   logic   dec_jr;
   logic   dec_jalr;
   logic   dec_bxx;
   rfidx_t dec_rs_idx;
   addr_t  dec_j_imm;
   addr_t  dec_b_imm;
   logic   rs_dep;
   logic [31:0] rs_rd_data;

   logic   rs_rd_en;
   rfidx_t rs_rd_idx;
   logic   prdt_vld;
   logic   prdt_taken;
   addr_t  prdt_pc;
   logic   bpu_wait;

   modport master (
      output inst_vld, flush, pc_incr, dec_bjp, dec_j, dec_jal, dec_jr, dec_jalr, dec_bxx,
             dec_rs_idx, dec_j_imm, dec_b_imm, rs_dep, rs_rd_data,
      input  rs_rd_en, rs_rd_idx, prdt_vld, prdt_taken, prdt_pc, bpu_wait
   );

   modport slave (
      input  inst_vld, flush, pc_incr, dec_bjp, dec_j, dec_jal, dec_jr, dec_jalr, dec_bxx,
             dec_rs_idx, dec_j_imm, dec_b_imm, rs_dep, rs_rd_data,
      output rs_rd_en, rs_rd_idx, prdt_vld, prdt_taken, prdt_pc, bpu_wait
   );

endinterface

// File: rtl/mips_if_ras.sv
// Circular return-address stack: ptr marks the next free slot, top is ptr-1.
// Pushing when full overwrites the oldest entry; push+pop together replaces the top in place.
module mips_if_ras
   import mips_if_litebpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  addr_t            push_val,
   output addr_t            top,
   output logic [CNT_W-1:0] count
);

   addr_t            entries [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] top_idx;

   assign top_idx = ptr - 1'b1;
   assign top     = entries[top_idx];

   // NOTE: the entries are small and must read as zero after reset, so they sit in the
   // reset branch like any other flop rather than in an unreset RAM-style block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (push && pop) begin
         // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
         entries[top_idx] <= push_val;
      end else if (push) begin
         entries[ptr] <= push_val;
         ptr          <= ptr + 1'b1;
         if (count != CNT_W'(DEPTH)) begin
            count <= count + 1'b1;
         end
      end else if (pop) begin
         ptr   <= ptr - 1'b1;
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mips_if_litebpu.sv
// Lite IF-stage branch predictor: static BTFN for Bxx, J/JAL always taken, JR/JALR via
// RAS for $31, zero for $0, otherwise a hazard-aware regfile read.
module mips_if_litebpu
   import mips_if_litebpu_pkg::*;
#(
   parameter int RAS_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mips_if_litebpu_if.slave        bus
);

   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   bpu_state_e       state, state_nxt;
   logic             ras_push, ras_pop;
   addr_t            ras_top;
   logic [CNT_W-1:0] ras_cnt;

   logic   prdt_vld, prdt_taken, bpu_wait, rs_rd_en;
   addr_t  prdt_pc;
   rfidx_t rs_rd_idx;

   mips_if_ras #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (ras_push),
      .pop      (ras_pop),
      .push_val (bus.pc_incr),
      .top      (ras_top),
      .count    (ras_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nxt  = state;
      prdt_vld   = 1'b0;
      prdt_taken = 1'b0;
      prdt_pc    = '0;
      bpu_wait   = 1'b0;
      rs_rd_en   = 1'b0;
      rs_rd_idx  = '0;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;

      // Outputs are combinational from the decoder, so reset must gate them directly.
      if (!rst_n) begin
         state_nxt = ST_IDLE;
      end else if (bus.flush) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.inst_vld) begin
                  if (!bus.dec_bjp) begin
                     prdt_vld = 1'b1;
                     prdt_pc  = bus.pc_incr;
                  end else if (bus.dec_j || bus.dec_jal) begin
                     prdt_vld   = 1'b1;
                     prdt_taken = 1'b1;
                     prdt_pc    = bus.dec_j_imm;
                     ras_push   = bus.dec_jal;
                  end else if (bus.dec_bxx) begin
                     prdt_vld   = 1'b1;
                     prdt_taken = is_backward(bus.dec_b_imm, bus.pc_incr);
                     prdt_pc    = prdt_taken ? bus.dec_b_imm : bus.pc_incr;
                  end else if (bus.dec_jr || bus.dec_jalr) begin
                     if (bus.dec_rs_idx == ZERO_IDX) begin
                        prdt_vld   = 1'b1;
                        prdt_taken = 1'b1;
                        ras_push   = bus.dec_jalr;
                     end else if (bus.dec_rs_idx == RA_IDX && ras_cnt != '0) begin
                        prdt_vld   = 1'b1;
                        prdt_taken = 1'b1;
                        prdt_pc    = ras_top;
                        ras_pop    = 1'b1;
                        ras_push   = bus.dec_jalr;
                     end else begin
                        bpu_wait  = 1'b1;
                        state_nxt = bus.rs_dep ? ST_WAIT : ST_READ;
                     end
                  end
               end
            end
            ST_WAIT: begin
               bpu_wait = 1'b1;
               if (!bus.rs_dep) state_nxt = ST_READ;
            end
            ST_READ: begin
               rs_rd_en   = 1'b1;
               rs_rd_idx  = bus.dec_rs_idx;
               prdt_vld   = 1'b1;
               prdt_taken = 1'b1;
               prdt_pc    = bus.rs_rd_data[ADDR_W-1:0];
               ras_push   = bus.dec_jalr;
               state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign bus.prdt_vld   = prdt_vld;
   assign bus.prdt_taken = prdt_taken;
   assign bus.prdt_pc    = prdt_pc;
   assign bus.bpu_wait   = bpu_wait;
   assign bus.rs_rd_en   = rs_rd_en;
   assign bus.rs_rd_idx  = rs_rd_idx;

endmodule

// File: tb/tb_mips_if_litebpu.sv
// Directed bench for mips_if_litebpu: inputs change on the falling edge, outputs are
// checked 1 ns later, and each comparison is an immediate assertion.
module tb_mips_if_litebpu;
   import mips_if_litebpu_pkg::*;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   mips_if_litebpu_if bus ();

   mips_if_litebpu #(.RAS_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_pred(input string tag, input logic vld, input logic tkn,
                           input logic [31:0] pc, input logic wt);
      check({tag, ".vld"},   32'(bus.prdt_vld),   32'(vld));
      check({tag, ".taken"}, 32'(bus.prdt_taken), 32'(tkn));
      check({tag, ".pc"},    bus.prdt_pc,         pc);
      check({tag, ".wait"},  32'(bus.bpu_wait),   32'(wt));
   endtask

   task automatic chk_rd(input string tag, input logic en, input logic [4:0] idx);
      check({tag, ".rd_en"},  32'(bus.rs_rd_en),  32'(en));
      check({tag, ".rd_idx"}, 32'(bus.rs_rd_idx), 32'(idx));
   endtask

   task automatic chk_zero(input string tag);
      chk_pred(tag, 1'b0, 1'b0, 32'h0, 1'b0);
      chk_rd(tag, 1'b0, 5'd0);
   endtask

   task automatic clr_dec();
      bus.dec_bjp    = 1'b0;
      bus.dec_j      = 1'b0;
      bus.dec_jal    = 1'b0;
      bus.dec_jr     = 1'b0;
      bus.dec_jalr   = 1'b0;
      bus.dec_bxx    = 1'b0;
      bus.dec_rs_idx = 5'd0;
      bus.dec_j_imm  = 32'h0;
      bus.dec_b_imm  = 32'h0;
   endtask

   task automatic clr_in();
      clr_dec();
      bus.inst_vld   = 1'b0;
      bus.flush      = 1'b0;
      bus.pc_incr    = 32'h0;
      bus.rs_dep     = 1'b0;
      bus.rs_rd_data = 32'h0;
   endtask

   task automatic drv_plain(input logic [31:0] pc);
      clr_dec();
      bus.inst_vld = 1'b1;
      bus.pc_incr  = pc;
   endtask

   task automatic drv_j(input logic link, input logic [31:0] pc, input logic [31:0] imm);
      drv_plain(pc);
      bus.dec_bjp   = 1'b1;
      bus.dec_j     = !link;
      bus.dec_jal   = link;
      bus.dec_j_imm = imm;
   endtask

   task automatic drv_b(input logic [31:0] pc, input logic [31:0] imm);
      drv_plain(pc);
      bus.dec_bjp   = 1'b1;
      bus.dec_bxx   = 1'b1;
      bus.dec_b_imm = imm;
   endtask

   task automatic drv_jr(input logic link, input logic [4:0] rs, input logic [31:0] pc);
      drv_plain(pc);
      bus.dec_bjp    = 1'b1;
      bus.dec_jr     = !link;
      bus.dec_jalr   = link;
      bus.dec_rs_idx = rs;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      clr_in();
      drv_j(1'b1, 32'h104, 32'h400);
      #2;
      chk_zero("reset");
      next_cycle();
      rst_n = 1'b1;

      // J, zero extra latency
      drv_j(1'b0, 32'h104, 32'h400);
      #1 chk_pred("j", 1, 1, 32'h400, 0);

      // Bxx: backward taken, forward not taken, equal not taken, unsigned compare
      next_cycle(); drv_b(32'h200, 32'h1F0);
      #1 chk_pred("bxx_bwd", 1, 1, 32'h1F0, 0);
      next_cycle(); drv_b(32'h200, 32'h240);
      #1 chk_pred("bxx_fwd", 1, 0, 32'h200, 0);
      next_cycle(); drv_b(32'h200, 32'h200);
      #1 chk_pred("bxx_eq", 1, 0, 32'h200, 0);
      next_cycle(); drv_b(32'h200, 32'h8000_0000);
      #1 chk_pred("bxx_unsigned", 1, 0, 32'h200, 0);

      // plain instruction and inst_vld low
      next_cycle(); drv_plain(32'h208);
      #1 chk_pred("plain", 1, 0, 32'h208, 0);
      next_cycle(); clr_in();
      #1 chk_zero("no_vld");

      // JAL then JR $31 from the RAS; a second JR $31 finds it empty
      next_cycle(); drv_j(1'b1, 32'h108, 32'h500);
      #1 chk_pred("jal", 1, 1, 32'h500, 0);
      next_cycle(); drv_jr(1'b0, 5'd31, 32'h10C);
      #1 chk_pred("jr31_ras", 1, 1, 32'h108, 0);
      next_cycle(); drv_jr(1'b0, 5'd31, 32'h10C);
      #1 chk_pred("jr31_empty", 0, 0, 32'h0, 1);
      next_cycle(); bus.rs_rd_data = 32'h7777;
      #1 chk_pred("jr31_read", 1, 1, 32'h7777, 0);
      chk_rd("jr31_read", 1, 5'd31);

      // JR $0 predicts address zero immediately
      next_cycle(); drv_jr(1'b0, 5'd0, 32'h300);
      #1 chk_pred("jr0", 1, 1, 32'h0, 0);

      // JR $8 with rs_dep high for three cycles
      next_cycle(); drv_jr(1'b0, 5'd8, 32'h310);
      for (int c = 0; c < 4; c++) begin
         if (c != 0) next_cycle();
         bus.rs_dep = (c < 3);
         #1 chk_pred($sformatf("jr8_wait%0d", c), 0, 0, 32'h0, 1);
         chk_rd($sformatf("jr8_wait%0d", c), 0, 5'd0);
      end
      next_cycle(); bus.rs_rd_data = 32'h3000;
      #1 chk_pred("jr8_read", 1, 1, 32'h3000, 0);
      chk_rd("jr8_read", 1, 5'd8);
      next_cycle(); drv_plain(32'h500);
      #1 chk_pred("after_read", 1, 0, 32'h500, 0);

      // five JALs overflow a 4-deep RAS; pops return E,D,C,B
      for (int i = 0; i < 5; i++) begin
         next_cycle(); drv_j(1'b1, 32'h1000 + 32'(4 * i), 32'h800);
         #1 check($sformatf("jal_fill%0d.pc", i), bus.prdt_pc, 32'h800);
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle(); drv_jr(1'b0, 5'd31, 32'h900);
         #1 chk_pred($sformatf("ras_pop%0d", i), 1, 1, 32'h1010 - 32'(4 * i), 0);
      end
      next_cycle(); drv_jr(1'b0, 5'd31, 32'h900);
      #1 chk_pred("ras_pop_empty", 0, 0, 32'h0, 1);
      next_cycle(); bus.rs_rd_data = 32'hABC;
      #1 chk_pred("ras_pop_read", 1, 1, 32'hABC, 0);

      // flush in WAIT returns to IDLE and leaves the RAS alone
      next_cycle(); drv_j(1'b1, 32'h2000, 32'h600);
      #1 chk_pred("jal_f", 1, 1, 32'h600, 0);
      next_cycle(); drv_jr(1'b0, 5'd9, 32'h2010); bus.rs_dep = 1'b1;
      #1 chk_pred("jr9_idle", 0, 0, 32'h0, 1);
      next_cycle();
      #1 chk_pred("jr9_wait", 0, 0, 32'h0, 1);
      bus.flush = 1'b1;
      #1 chk_zero("flush_wait");
      next_cycle(); bus.flush = 1'b0; bus.rs_dep = 1'b0; drv_jr(1'b0, 5'd31, 32'h2100);
      #1 chk_pred("after_flush_ras", 1, 1, 32'h2000, 0);

      // a flushed JALR must not push
      next_cycle(); drv_jr(1'b1, 5'd0, 32'h2200); bus.flush = 1'b1;
      #1 chk_zero("flush_jalr");
      next_cycle(); bus.flush = 1'b0; drv_jr(1'b0, 5'd31, 32'h2300);
      #1 chk_pred("flush_jalr_nopush", 0, 0, 32'h0, 1);
      next_cycle(); bus.rs_rd_data = 32'h44;
      #1 chk_pred("flush_jalr_read", 1, 1, 32'h44, 0);

      // JALR $31 with a non-empty RAS: pop and push together
      next_cycle(); drv_j(1'b1, 32'h3300, 32'h700);
      #1 chk_pred("jal_pp", 1, 1, 32'h700, 0);
      next_cycle(); drv_jr(1'b1, 5'd31, 32'h3404);
      #1 chk_pred("jalr31_pp", 1, 1, 32'h3300, 0);
      next_cycle(); drv_jr(1'b0, 5'd31, 32'h3500);
      #1 chk_pred("jr_after_pp", 1, 1, 32'h3404, 0);
      next_cycle(); drv_jr(1'b0, 5'd31, 32'h3600);
      #1 chk_pred("pp_empty", 0, 0, 32'h0, 1);

      // reset asserted in the middle of READ zeroes outputs at once
      next_cycle(); bus.rs_rd_data = 32'h55;
      #1 chk_rd("pre_rst_read", 1, 5'd31);
      rst_n = 1'b0;
      #1 chk_zero("rst_read");
      next_cycle(); rst_n = 1'b1; drv_plain(32'h800);
      #1 chk_pred("post_rst_idle", 1, 0, 32'h800, 0);
      next_cycle(); drv_jr(1'b0, 5'd31, 32'h804);
      #1 chk_pred("post_rst_ras_empty", 0, 0, 32'h0, 1);
      next_cycle(); bus.flush = 1'b1;
      #1 chk_zero("final_flush");
      next_cycle(); clr_in();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
